// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcodes and EX-stage FSM encoding for the 8-bit pipeline
package cpu_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_REG_AW = 3;
  localparam int DEF_OP_W   = 3;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_MUL_WB  = 2'd2
  } ex_state_t;
endpackage

// File: rtl/ex_mul_iter.sv
// rtl/ex_mul_iter.sv - iterative shift-add multiplier, one partial product per clock (EX_MUL_EN only)
module ex_mul_iter import cpu_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  last,
  output logic [2*DATA_W-1:0]   product
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;
  logic                running;

  // product is final on the edge where last is high and then holds until the next start
  assign last = running && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      product <= '0;
      mcand   <= {{DATA_W{1'b0}}, a};
      mplier  <= b;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) running <= 1'b0;
    end
  end
endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - EX stage: combinational ALU feeding a registered EX/WB bundle with valid/ready
// EX_MUL_EN adds the iterative multiplier and its IDLE/MUL_RUN/MUL_WB FSM; otherwise opcode 111 is a NOP.
module ex_stage import cpu_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opcode_in,
  input  logic [DATA_W-1:0] rs1_data_in,
  input  logic [DATA_W-1:0] rs2_data_in,
  input  logic [REG_AW-1:0] rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              wb_en_out,
  output logic              carry_out,
  output logic              zero_out,
  output logic              busy
);
  localparam int SH_W = $clog2(DATA_W);

  logic              out_free, idle, accept, load_alu, load_mul, mul_start;
  logic [DATA_W-1:0] alu_res, mul_res;
  logic              alu_carry, alu_wb, mul_carry;
  logic [DATA_W:0]   sum;
  logic [REG_AW-1:0] mul_rd;

  assign out_free = !out_valid || out_ready;
  assign in_ready = !rst && idle && out_free;
  assign accept   = in_valid && in_ready;
  assign load_alu = accept && !mul_start;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_wb    = 1'b1;
    sum       = {1'b0, rs1_data_in} + {1'b0, rs2_data_in};
    case (opcode_in)
      OP_ADD: begin alu_res = sum[DATA_W-1:0]; alu_carry = sum[DATA_W]; end
      OP_SUB: begin alu_res = rs1_data_in - rs2_data_in; alu_carry = (rs1_data_in < rs2_data_in); end
      OP_AND: alu_res = rs1_data_in & rs2_data_in;
      OP_OR:  alu_res = rs1_data_in | rs2_data_in;
      OP_XOR: alu_res = rs1_data_in ^ rs2_data_in;
      OP_SHL: alu_res = rs1_data_in << rs2_data_in[SH_W-1:0];
      default: alu_wb = 1'b0; // NOP slot; MUL lands here only when it goes through the FSM or is not built
    endcase
  end

`ifdef EX_MUL_EN
  ex_state_t           state;
  logic                mul_last;
  logic [2*DATA_W-1:0] product;

  assign idle      = (state == ST_IDLE);
  assign busy      = !idle;
  assign mul_start = accept && (opcode_in == OP_MUL);
  assign load_mul  = (state == ST_MUL_WB) && out_free;
  assign mul_res   = product[DATA_W-1:0];
  assign mul_carry = |product[2*DATA_W-1:DATA_W];

  ex_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (rs1_data_in),
    .b       (rs2_data_in),
    .last    (mul_last),
    .product (product)
  );
`else
  assign idle      = 1'b1;
  assign busy      = 1'b0;
  assign mul_start = 1'b0;
  assign load_mul  = 1'b0;
  assign mul_res   = '0;
  assign mul_carry = 1'b0;
  assign mul_rd    = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      result_out <= '0;
      rd_out     <= '0;
      wb_en_out  <= 1'b0;
      carry_out  <= 1'b0;
      zero_out   <= 1'b0;
`ifdef EX_MUL_EN
      state      <= ST_IDLE;
      mul_rd     <= '0;
`endif
    end else begin
      if (load_alu) begin
        out_valid  <= 1'b1;
        result_out <= alu_res;
        rd_out     <= rd_in;
        wb_en_out  <= alu_wb;
        carry_out  <= alu_carry;
        zero_out   <= alu_wb && (alu_res == '0);
      end else if (load_mul) begin
        out_valid  <= 1'b1;
        result_out <= mul_res;
        rd_out     <= mul_rd;
        wb_en_out  <= 1'b1;
        carry_out  <= mul_carry;
        zero_out   <= (mul_res == '0);
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
`ifdef EX_MUL_EN
      case (state)
        ST_IDLE:    if (mul_start) begin state <= ST_MUL_RUN; mul_rd <= rd_in; end
        ST_MUL_RUN: if (mul_last) state <= ST_MUL_WB;
        ST_MUL_WB:  if (load_mul) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
`endif
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage; MUL scenarios follow EX_MUL_EN
`timescale 1ns/1ps
module tb_ex_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic [7:0] res;
    logic [2:0] rd;
    logic       wb;
    logic       c;
    logic       z;
  } exp_t;

  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0] opcode_in = '0, rd_in = '0;
  logic [7:0] rs1_data_in = '0, rs2_data_in = '0;
  logic       in_ready, out_valid, wb_en_out, carry_out, zero_out, busy;
  logic [7:0] result_out;
  logic [2:0] rd_out;

  exp_t sb[$];
  exp_t e, got;
  int   tests = 0, fails = 0;
  logic busy_seen = 1'b0;

  ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode_in(opcode_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out), .rd_out(rd_out),
    .wb_en_out(wb_en_out), .carry_out(carry_out), .zero_out(zero_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (busy === 1'b1) busy_seen = 1'b1;
  assign got = exp_t'({result_out, rd_out, wb_en_out, carry_out, zero_out});

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] rd);
    exp_t m;
    logic [8:0] s;
    logic [15:0] p;
    m = '0; m.rd = rd; m.wb = 1'b1;
    s = {1'b0, a} + {1'b0, b};
    p = {8'h00, a} * {8'h00, b};
    case (op)
      3'd1: begin m.res = s[7:0]; m.c = s[8]; end
      3'd2: begin m.res = a - b; m.c = (a < b); end
      3'd3: m.res = a & b;
      3'd4: m.res = a | b;
      3'd5: m.res = a ^ b;
      3'd6: m.res = a << b[2:0];
`ifdef EX_MUL_EN
      3'd7: begin m.res = p[7:0]; m.c = |p[15:8]; end
`endif
      default: begin m.res = 8'h00; m.wb = 1'b0; end
    endcase
    m.z = m.wb && (m.res == 8'h00);
    return m;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [2:0] rd);
    opcode_in = op; rs1_data_in = a; rs2_data_in = b; rd_in = rd; in_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, in_ready, busy, got} !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h required 0", {out_valid, in_ready, busy, got});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_add();
    @(posedge clk); #1; out_ready = 1'b1;
    sb.push_back({8'h10, 3'd3, 3'b110});
    send(OP_ADD, 8'hF0, 8'h20, 3'd3);
    @(negedge clk);
    tests++; e = sb.pop_front();
    if (out_valid !== 1'b1 || got !== e) begin
      fails++; $display("FAIL add_f0_20: valid=%b got %h required valid=1 %h", out_valid, got, e);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1; out_ready = 1'b1;
    opcode_in = OP_SUB; rs1_data_in = 8'h05; rs2_data_in = 8'h05; rd_in = 3'd1; in_valid = 1'b1;
    sb.push_back({8'h00, 3'd1, 3'b101});
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
    rs1_data_in = 8'h03; rs2_data_in = 8'h07; rd_in = 3'd2;
    sb.push_back({8'hFC, 3'd2, 3'b110});
    @(negedge clk);
    tests++; e = sb.pop_front();
    if (out_valid !== 1'b1 || got !== e || in_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_sub_zero: valid=%b rdy=%b got %h required %h", out_valid, in_ready, got, e);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    tests++; e = sb.pop_front();
    if (out_valid !== 1'b1 || got !== e) begin
      fails++; $display("FAIL b2b_sub_borrow: valid=%b got %h required %h", out_valid, got, e);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: valid=%b required 0", out_valid); end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1; out_ready = 1'b0;
    sb.push_back({8'h55, 3'd4, 3'b100});
    send(OP_XOR, 8'hAA, 8'hFF, 3'd4);
    opcode_in = OP_AND; rs1_data_in = 8'h0F; rs2_data_in = 8'h3C; rd_in = 3'd6; in_valid = 1'b1;
    sb.push_back({8'h0C, 3'd6, 3'b100});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || got !== sb[0] || in_ready !== 1'b0) begin
        fails++; $display("FAIL bp_hold_%0d: valid=%b rdy=%b got %h required valid=1 rdy=0 %h", i, out_valid, in_ready, got, sb[0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++; e = sb.pop_front();
    if (got !== e || in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release: rdy=%b got %h required rdy=1 %h", in_ready, got, e);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    tests++; e = sb.pop_front();
    if (out_valid !== 1'b1 || got !== e) begin
      fails++; $display("FAIL bp_next: valid=%b got %h required %h", out_valid, got, e);
    end
  endtask

  task automatic test_nop();
    @(posedge clk); #1; out_ready = 1'b1;
    sb.push_back({8'h00, 3'd1, 3'b000});
    send(OP_NOP, 8'h12, 8'h34, 3'd1);
    @(negedge clk);
    tests++; e = sb.pop_front();
    if (out_valid !== 1'b1 || got !== e) begin
      fails++; $display("FAIL nop: valid=%b got %h required %h", out_valid, got, e);
    end
`ifndef EX_MUL_EN
    @(posedge clk); #1;
    sb.push_back({8'h00, 3'd2, 3'b000});
    send(OP_MUL, 8'h12, 8'h34, 3'd2);
    @(negedge clk);
    tests++; e = sb.pop_front();
    if (out_valid !== 1'b1 || got !== e) begin
      fails++; $display("FAIL mul_as_nop: valid=%b got %h required %h", out_valid, got, e);
    end
    tests++;
    if (busy_seen !== 1'b0) begin fails++; $display("FAIL busy_never: got %b required 0", busy_seen); end
`endif
  endtask

`ifdef EX_MUL_EN
  task automatic test_mul();
    int   edges;
    logic stall_ok;
    logic [7:0] av [2];
    logic [7:0] bv [2];
    exp_t ev [2];
    av[0] = 8'h0D; bv[0] = 8'h0B; ev[0] = {8'h8F, 3'd5, 3'b100};
    av[1] = 8'h20; bv[1] = 8'h10; ev[1] = {8'h00, 3'd6, 3'b111};
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1; out_ready = 1'b1;
      sb.push_back(ev[k]);
      send(OP_MUL, av[k], bv[k], ev[k].rd);
      edges = 0; stall_ok = 1'b1;
      while (edges < 20) begin
        @(negedge clk);
        if (out_valid) break;
        if (busy !== 1'b1 || in_ready !== 1'b0) stall_ok = 1'b0;
        @(posedge clk); #1;
        edges++;
      end
      tests++;
      if (!stall_ok) begin fails++; $display("FAIL mul_stall_%0d: busy/in_ready wrong while running", k); end
      tests++;
      if (edges !== 9) begin fails++; $display("FAIL mul_latency_%0d: got %0d edges required 9", k, edges); end
      tests++; e = sb.pop_front();
      if (out_valid !== 1'b1 || got !== e || busy !== 1'b0) begin
        fails++; $display("FAIL mul_result_%0d: valid=%b busy=%b got %h required %h", k, out_valid, busy, got, e);
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    logic ok;
    @(posedge clk); #1; out_ready = 1'b1;
`ifdef EX_MUL_EN
    send(OP_MUL, 8'h0D, 8'h0B, 3'd5);
    repeat (3) @(posedge clk);
`else
    out_ready = 1'b0;
    send(OP_ADD, 8'hFF, 8'h01, 3'd7);
    repeat (2) @(posedge clk);
`endif
    #2; rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, busy, got} !== '0) begin
      fails++; $display("FAIL rst_async_clear: got %h required 0", {out_valid, busy, got});
    end
    #1; rst = 1'b0; out_ready = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL rst_discard: aborted op resurfaced"); end
    @(posedge clk); #1;
    sb.push_back({8'h02, 3'd7, 3'b100});
    send(OP_ADD, 8'h01, 8'h01, 3'd7);
    @(negedge clk);
    tests++; e = sb.pop_front();
    if (out_valid !== 1'b1 || got !== e) begin
      fails++; $display("FAIL rst_then_add: valid=%b got %h required %h", out_valid, got, e);
    end
  endtask

  task automatic test_random();
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef EX_MUL_EN
      opcode_in = 3'($urandom_range(0, 6));
`else
      opcode_in = 3'($urandom_range(0, 7));
`endif
      rs1_data_in = 8'($urandom); rs2_data_in = 8'($urandom); rd_in = 3'($urandom);
      @(negedge clk);
      if (out_valid && out_ready) begin
        tests++;
        if (sb.size() == 0) begin fails++; $display("FAIL rand_extra: output %h with nothing expected", got); end
        else begin
          e = sb.pop_front();
          if (got !== e) begin fails++; $display("FAIL rand_result: got %h required %h", got, e); end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(opcode_in, rs1_data_in, rs2_data_in, rd_in));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && sb.size() != 0; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        tests++; e = sb.pop_front();
        if (got !== e) begin fails++; $display("FAIL rand_tail: got %h required %h", got, e); end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL rand_drain: %0d results missing required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_nop();
`ifdef EX_MUL_EN
    test_mul();
`endif
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
